lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the data-memory interface.
- Accepts one load or store request from the execute stage and checks alignment.
- Drives a held request/acknowledge transaction to the data memory, then returns sign- or zero-extended load data, or an exception, to writeback.
- One transaction in flight; the pipeline stalls on req_ready low.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (fixed at 64; byte-lane math assumes 8 lanes).
- TIMEOUT_CYCLES, 16, cycles of mem_req without mem_ack before a forced access fault (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_is_load  in  1  load request.
- req_is_store  in  1  store request; wins if both set.
- req_funct3  in  3  RISC-V funct3: [1:0] size (B/H/W/D), [2] unsigned (loads only).
- req_addr  in  64  effective address.
- req_wdata  in  64  store data; low bytes used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and exceptions.
- exc_en  out  1  exception, valid with resp_valid.
- exc_code  out  4  4/5/6/7 = load misaligned / load fault / store misaligned / store fault.
- exc_val  out  64  faulting address.
- mem_req  out  1  memory request held until ack.
- mem_we  out  1  store.
- mem_is_load  out  1  load.
- mem_word_sel  out  8  byte mask: 01/03/0F/FF for B/H/W/D.
- mem_addr  out  64  address.
- mem_wdata  out  64  store data, byte n on lanes [8n+7:8n], unshifted.
- mem_rdata  in  64  load data, lane 0 = byte at mem_addr.
- mem_ack  in  1  memory completes this cycle.
- mem_err  in  1  access fault, valid with mem_ack.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE.
  - req_ready = 1.
  - mem_req, mem_we, mem_is_load, resp_valid, exc_en = 0.
  - All data/address/code outputs = 0.
  - A transaction in progress is abandoned; mem_req drops immediately.
- States: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid && req_ready; latch addr, wdata, funct3, type.
  - Misaligned (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0) -> RESP with exc_en=1, code 4 (load) or 6 (store), exc_val=addr. No memory access.
  - Neither load nor store -> RESP, no exception, resp_rdata=0.
  - Otherwise -> ISSUE.
- ISSUE:
  - mem_req = 1; mem_* outputs stable for the whole state.
  - On mem_ack -> RESP.
  - If mem_err is also set: exc_en=1, code 5 (load) or 7 (store), exc_val=addr.
  - Otherwise for loads, capture mem_rdata and extend:
    - B: bits [7:0]; H: bits [15:0]; W: bits [31:0].
    - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
    - D: all 64 bits; funct3=111 is treated as LD.
  - mem_req deasserts on the cycle after ack is sampled.
- RESP:
  - resp_valid = 1 for exactly one cycle, then -> IDLE.
  - req_ready = 0 in ISSUE and RESP.
- Latency:
  - Accept at edge N; mem_req high from N+1; ack sampled at edge M; resp_valid high in cycle M+1.
  - Zero-wait memory (ack on first mem_req cycle) gives 3 cycles accept-to-response.
  - Misaligned requests give 2 cycles.
- req_valid is ignored outside IDLE. A request arriving in the same cycle as resp_valid is not accepted; it is taken next cycle.
- mem_ack outside ISSUE is ignored.
- Store data beyond the access size is driven as 0 on mem_wdata.
- exc_en, exc_code, exc_val hold their values until the next resp_valid; resp_rdata is likewise held.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on ISSUE entry and increments each ISSUE cycle without mem_ack.
  - At TIMEOUT_CYCLES it forces -> RESP with code 5 or 7, exc_val=addr, and mem_req drops.
  - A mem_ack on the same edge as the timeout wins.
- Undefined: no counter; ISSUE waits for mem_ack indefinitely.

Test Plan:
- LB addr 0x10, mem_rdata=0x...80, funct3=000 -> resp_rdata=0xFFFFFFFFFFFFFF80, mem_word_sel=0x01; same access with funct3=100 -> 0x80.
- SW addr 0x20, wdata=0x1122334455667788, ack after 3 wait cycles -> mem_we=1, mem_word_sel=0x0F, mem_wdata=0x55667788, mem_req held 4 cycles, resp_valid in the following cycle, exc_en=0.
- LD addr 0x1004 -> no mem_req; resp_valid 2 cycles after accept with exc_code=4, exc_val=0x1004. SH addr 0x3 -> exc_code=6.
- LW addr 0x2000 with mem_ack+mem_err -> exc_code=5, exc_val=0x2000, resp_rdata=0.
- rst pulled low during ISSUE -> mem_req=0 and req_ready=1 immediately; after release, a new LD completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, store never acked -> exactly 4 mem_req cycles, then exc_code=7.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a held req/ack data-memory transaction and returning extended load data or exceptions.
// Optional ISSUE-state watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              exc_en,
  output logic [3:0]        exc_code,
  output logic [ADDR_W-1:0] exc_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_is_load,
  output logic [7:0]        mem_word_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_d;
  logic [2:0] f3, f3_d;
  logic ready_d, mreq_d, we_d, ld_d, rv_d, exc_d;
  logic [7:0] sel_d, sel_new;
  logic [ADDR_W-1:0] addr_d, val_d;
  logic [DATA_W-1:0] wdata_d, rdata_d, wmask, ld_ext;
  logic [3:0] code_d;
  logic is_ld, is_st, misal, timeout, fault;
  assign is_st = req_is_store;
  assign is_ld = req_is_load && !req_is_store;
  assign sel_new = req_funct3[1:0] == 2'd0 ? 8'h01 : req_funct3[1:0] == 2'd1 ? 8'h03 :
                   req_funct3[1:0] == 2'd2 ? 8'h0f : 8'hff;
  assign misal = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'd2 && |req_addr[1:0]) ||
                 (req_funct3[1:0] == 2'd3 && |req_addr[2:0]);
  always_comb for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{sel_new[i]}};
  // funct3[2] selects zero-extension; doubleword ignores it so 111 behaves as LD
  assign ld_ext = f3[1:0] == 2'd0 ? {{56{!f3[2] && mem_rdata[7]}}, mem_rdata[7:0]} :
                  f3[1:0] == 2'd1 ? {{48{!f3[2] && mem_rdata[15]}}, mem_rdata[15:0]} :
                  f3[1:0] == 2'd2 ? {{32{!f3[2] && mem_rdata[31]}}, mem_rdata[31:0]} : mem_rdata;
  // an ack on the timeout edge wins, so a fault is either mem_err or an unacked timeout
  assign fault = !mem_ack || mem_err;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= state == ISSUE ? cnt + 1'b1 : '0;
  assign timeout = state == ISSUE && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state;
    f3_d = f3;
    ready_d = req_ready;
    mreq_d = mem_req;
    we_d = mem_we;
    ld_d = mem_is_load;
    sel_d = mem_word_sel;
    addr_d = mem_addr;
    wdata_d = mem_wdata;
    rv_d = 1'b0;
    rdata_d = resp_rdata;
    exc_d = exc_en;
    code_d = exc_code;
    val_d = exc_val;
    case (state)
      IDLE: if (req_valid) begin
        ready_d = 1'b0;
        if ((is_ld || is_st) && !misal) begin
          state_d = ISSUE;
          f3_d = req_funct3;
          mreq_d = 1'b1;
          we_d = is_st;
          ld_d = is_ld;
          sel_d = sel_new;
          addr_d = req_addr;
          wdata_d = req_wdata & wmask;
        end else begin
          state_d = RESP;
          rv_d = 1'b1;
          rdata_d = '0;
          exc_d = misal && (is_ld || is_st);
          code_d = !exc_d ? 4'd0 : is_st ? 4'd6 : 4'd4;
          val_d = exc_d ? req_addr : '0;
        end
      end
      ISSUE: if (mem_ack || timeout) begin
        state_d = RESP;
        mreq_d = 1'b0;
        we_d = 1'b0;
        ld_d = 1'b0;
        rv_d = 1'b1;
        exc_d = fault;
        code_d = !fault ? 4'd0 : mem_we ? 4'd7 : 4'd5;
        val_d = fault ? mem_addr : '0;
        rdata_d = fault || mem_we ? '0 : ld_ext;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      f3 <= '0;
      req_ready <= 1'b1;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_is_load <= 1'b0;
      mem_word_sel <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      exc_en <= 1'b0;
      exc_code <= '0;
      exc_val <= '0;
    end else begin
      state <= state_d;
      f3 <= f3_d;
      req_ready <= ready_d;
      mem_req <= mreq_d;
      mem_we <= we_d;
      mem_is_load <= ld_d;
      mem_word_sel <= sel_d;
      mem_addr <= addr_d;
      mem_wdata <= wdata_d;
      resp_valid <= rv_d;
      resp_rdata <= rdata_d;
      exc_en <= exc_d;
      exc_code <= code_d;
      exc_val <= val_d;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized scoreboard bench for lsu_ctrl with a behavioural memory responder.
module tb_lsu_ctrl;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_is_load = 0, req_is_store = 0, mem_ack = 0, mem_err = 0;
  logic [2:0] req_funct3 = 0;
  logic [63:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic req_ready, resp_valid, exc_en, mem_req, mem_we, mem_is_load;
  logic [3:0] exc_code;
  logic [7:0] mem_word_sel;
  logic [63:0] resp_rdata, exc_val, mem_addr, mem_wdata;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_load(mem_is_load),
    .mem_word_sel(mem_word_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    bit en;
    logic [3:0] code;
    logic [63:0] val;
    longint cyc;
  } exp_t;
  typedef struct {
    bit we, ld;
    logic [7:0] sel;
    logic [63:0] addr, wdata, rdata;
    int wt;
    bit err;
  } mem_t;
  exp_t eq[$];
  mem_t mq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bmask(input int nb);
    return nb == 8 ? 64'hffff_ffff_ffff_ffff : (64'd1 << (8 * nb)) - 64'd1;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] d, input logic [2:0] f3);
    int nb;
    logic [63:0] m, v;
    nb = 1 << f3[1:0];
    m = bmask(nb);
    v = d & m;
    if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic junk();
    req_valid = 1'($urandom);
    req_is_load = 1'($urandom);
    req_is_store = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd, input int wt, input bit er);
    int nb, g;
    exp_t e;
    mem_t m;
    nb = 1 << f3[1:0];
    g = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && g < 200) begin
      junk();
      @(negedge clk);
      g++;
    end
    if (req_ready !== 1'b1) begin
      chk("accept_wait", req_ready, 1);
      return;
    end
    req_valid = 1; req_is_load = ld; req_is_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    e.cyc = cyc + 1; e.rdata = 0; e.en = 0; e.code = 0; e.val = 0;
    if (ld || st) begin
      if ((addr & 64'(nb - 1)) != 0) begin
        e.en = 1; e.code = st ? 4'd6 : 4'd4; e.val = addr;
      end else begin
        m.we = st; m.ld = !st; m.sel = 8'((1 << nb) - 1); m.addr = addr;
        m.wdata = wd & bmask(nb); m.rdata = rd; m.wt = wt; m.err = er;
        mq.push_back(m);
        e.cyc = cyc + 2 + wt;
        if (er) begin
          e.en = 1; e.code = st ? 4'd7 : 4'd5; e.val = addr;
        end else if (!st) e.rdata = ext(rd, f3);
      end
    end
    eq.push_back(e);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  // response monitor: pops the scoreboard on every resp_valid pulse
  always @(negedge clk) if (rst) begin
    exp_t e;
    if (mem_req || resp_valid) chk("ready_low", req_ready, 0);
    if (resp_valid) begin
      if (eq.size() == 0) chk("unexpected_resp", resp_valid, 0);
      else begin
        e = eq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("exc_en", exc_en, e.en);
        chk("exc_code", exc_code, e.code);
        chk("exc_val", exc_val, e.val);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // memory responder: checks the request fields and acks after the planned wait
  mem_t cur;
  bit active = 0, acked = 0;
  int cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      active = 0; acked = 0; mem_ack = 0; mem_err = 0;
    end else begin
      if (acked) begin
        chk("mem_req_drop", mem_req, 0);
        acked = 0;
      end
      if (mem_req) begin
        if (!active) begin
          if (mq.size() == 0) chk("unexpected_mem_req", mem_req, 0);
          else begin
            cur = mq.pop_front();
            active = 1;
            cnt = 0;
          end
        end
        if (active) begin
          chk("mem_we", mem_we, cur.we);
          chk("mem_is_load", mem_is_load, cur.ld);
          chk("mem_word_sel", mem_word_sel, cur.sel);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wdata);
          if (cnt == cur.wt) begin
            mem_ack = 1; mem_err = cur.err; mem_rdata = cur.rdata;
            active = 0; acked = 1;
          end else begin
            mem_ack = 0; mem_err = 1'($urandom); mem_rdata = {$urandom, $urandom};
          end
          cnt++;
        end
      end else begin
        mem_ack = ($urandom % 4) == 0;
        mem_err = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    logic [2:0] f3;
    logic [63:0] a;
    int r, g;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_exc_code", exc_code, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1;
    issue(1, 0, 3'b000, 64'h10, 64'h0, 64'h1234_5678_90ab_cd80, 0, 0);
    issue(1, 0, 3'b100, 64'h10, 64'h0, 64'h1234_5678_90ab_cd80, 1, 0);
    issue(0, 1, 3'b010, 64'h20, 64'h1122_3344_5566_7788, 64'h0, 3, 0);
    issue(1, 0, 3'b011, 64'h1004, 64'h0, 64'h0, 0, 0);
    issue(0, 1, 3'b001, 64'h3, 64'hffff, 64'h0, 0, 0);
    issue(1, 0, 3'b010, 64'h2000, 64'h0, 64'hdead_beef_dead_beef, 2, 1);
    issue(1, 0, 3'b111, 64'h18, 64'h0, 64'h8000_0000_0000_0001, 0, 0);
    issue(1, 1, 3'b001, 64'h42, 64'h1234_abcd, 64'h0, 1, 0);
    issue(0, 0, 3'b011, 64'h7, 64'h0, 64'h0, 0, 0);
    // asynchronous reset while a load waits in ISSUE
    issue(1, 0, 3'b011, 64'h40, 64'h0, 64'h5, 30, 0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_req_ready", req_ready, 1);
    chk("async_rst_resp_valid", resp_valid, 0);
    eq.delete();
    mq.delete();
    @(negedge clk);
    #2 rst = 1;
    issue(1, 0, 3'b011, 64'h88, 64'h0, 64'hfedc_ba98_7654_3210, 1, 0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom % 10;
      f3 = 3'($urandom);
      a = {$urandom, $urandom};
      if ($urandom % 10 < 7) a = a & ~64'((1 << f3[1:0]) - 1);
      issue(r < 4 || r == 8, r >= 4 && r <= 8, f3, a, {$urandom, $urandom},
            {$urandom, $urandom}, $urandom % 5, ($urandom % 8) == 0);
    end
    g = 0;
    while (eq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("drain_resp", eq.size(), 0);
    chk("drain_mem", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
